// File: rtl/trace_pkg.sv
// Shared definitions for the trace transmitter.
// Optional feature macro: TRACE_CHECKSUM_EN appends an XOR checksum byte.
package trace_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef TRACE_CHECKSUM_EN
    localparam int FRAME_BYTES = 9;
`else
    localparam int FRAME_BYTES = 8;
`endif

    localparam int IDX_W = $clog2(FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Bit-level 8N1 serialiser. Handshake: a byte is taken on any edge where
// load=1 and ready=1. ready is high while idle and during the final cycle of
// the stop bit, so a byte loaded then starts with no idle gap.
module uart_tx_byte
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             tick;

    assign tick  = (cnt_q == CNT_LAST);
    assign ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
    assign tx    = tx_q;

    // Next-state logic: bit timing, shifting, and byte hand-off.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;

        if (state_q != ST_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (load && ready) begin
            state_d = ST_START;
            cnt_d   = '0;
            shreg_d = data;
        end

        // Line level is registered so tx never glitches.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/trace_tx.sv
// Debug trace transmitter: snapshots opcode/A/B/ZNC on capture and sends
// them as a fixed byte frame over an 8N1 line.
// Optional feature macro: TRACE_CHECKSUM_EN (adds XOR of bytes 1..7).
module trace_tx
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DROP_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [15:0]       op_in,
    input  logic [15:0]       a_in,
    input  logic [15:0]       b_in,
    input  logic [2:0]        znc_in,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [15:0]       op_q, op_d, a_q, a_d, b_q, b_d;
    logic [2:0]        znc_q, znc_d;

    logic              byte_ready;
    logic              byte_load;
    logic [7:0]        byte_data;
    logic [IDX_W-1:0]  byte_sel;
    logic              accept, last_done;

`ifdef TRACE_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = op_q[15:8] ^ op_q[7:0] ^ a_q[15:8] ^ a_q[7:0]
                ^ b_q[15:8] ^ b_q[7:0] ^ {5'b0, znc_q};
`endif

    assign accept     = capture && !busy_q;
    assign last_done  = busy_q && byte_ready && (byte_idx_q == IDX_LAST);
    assign busy       = busy_q;
    assign frame_done = last_done;
    assign drop_cnt   = drop_q;

    // Frame sequencing, snapshot capture and refused-capture counting.
    always_comb begin
        busy_d     = busy_q;
        byte_idx_d = byte_idx_q;
        drop_d     = drop_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        znc_d      = znc_q;
        byte_load  = 1'b0;
        byte_sel   = byte_idx_q + IDX_W'(1);

        if (accept) begin
            busy_d     = 1'b1;
            byte_idx_d = '0;
            byte_sel   = '0;
            byte_load  = 1'b1;
            op_d       = op_in;
            a_d        = a_in;
            b_d        = b_in;
            znc_d      = znc_in;
        end else if (busy_q && byte_ready) begin
            if (byte_idx_q == IDX_LAST) begin
                busy_d     = 1'b0;
                byte_idx_d = '0;
            end else begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
                byte_load  = 1'b1;
            end
        end

        if (capture && busy_q && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // Byte selection for the serialiser; sync byte comes from the constant.
    always_comb begin
        case (int'(byte_sel))
            0:       byte_data = SYNC_BYTE;
            1:       byte_data = op_q[15:8];
            2:       byte_data = op_q[7:0];
            3:       byte_data = a_q[15:8];
            4:       byte_data = a_q[7:0];
            5:       byte_data = b_q[15:8];
            6:       byte_data = b_q[7:0];
            7:       byte_data = {5'b0, znc_q};
`ifdef TRACE_CHECKSUM_EN
            8:       byte_data = csum;
`endif
            default: byte_data = 8'h00;
        endcase
    end

    // Sequencer and snapshot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            byte_idx_q <= '0;
            drop_q     <= '0;
            op_q       <= 16'h0000;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            znc_q      <= 3'b000;
        end else begin
            busy_q     <= busy_d;
            byte_idx_q <= byte_idx_d;
            drop_q     <= drop_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            znc_q      <= znc_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (byte_load),
        .data  (byte_data),
        .ready (byte_ready),
        .tx    (tx)
    );

endmodule

// File: tb/tb_trace_tx.sv
// Bench for trace_tx with CLKS_PER_BIT=4: frame-level model, line decoder
// and directed scenarios with literal expectations.
module tb_trace_tx;
  import trace_pkg::*;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int NB    = FRAME_BYTES;
  localparam int NBITS = NB * 10;
  localparam int TOTAL = NBITS * CPB;
  localparam int DMAX  = (1 << DW) - 1;
`ifdef TRACE_CHECKSUM_EN
  localparam int BUSY_LIT = 360;
`else
  localparam int BUSY_LIT = 320;
`endif

  logic          clk;
  logic          rst_n;
  logic          capture;
  logic [15:0]   op_in, a_in, b_in;
  logic [2:0]    znc_in;
  logic          tx, busy, frame_done;
  logic [DW-1:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;

  trace_tx #(.CLKS_PER_BIT(CPB), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .capture(capture),
    .op_in(op_in), .a_in(a_in), .b_in(b_in), .znc_in(znc_in),
    .tx(tx), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- frame-level model ----------------
  logic bits_m[0:NBITS-1];
  bit   busy_m = 0;
  int   t_m    = 0;
  int   drop_m = 0;

  always @(posedge clk) begin
    logic [7:0] fr[0:NB-1];
    if (!rst_n) begin
      busy_m = 0; t_m = 0; drop_m = 0;
    end else if (busy_m) begin
      if (capture && drop_m < DMAX) drop_m++;
      t_m++;
      if (t_m == TOTAL) begin busy_m = 0; t_m = 0; end
    end else if (capture) begin
      fr[0] = 8'hA5;
      fr[1] = op_in[15:8]; fr[2] = op_in[7:0];
      fr[3] = a_in[15:8];  fr[4] = a_in[7:0];
      fr[5] = b_in[15:8];  fr[6] = b_in[7:0];
      fr[7] = {5'b0, znc_in};
`ifdef TRACE_CHECKSUM_EN
      fr[8] = 8'h00;
      for (int i = 1; i < 8; i++) fr[8] = fr[8] ^ fr[i];
`endif
      for (int i = 0; i < NB; i++) begin
        bits_m[i*10] = 1'b0;
        for (int j = 0; j < 8; j++) bits_m[i*10+1+j] = fr[i][j];
        bits_m[i*10+9] = 1'b1;
      end
      busy_m = 1; t_m = 0;
    end
  end

  // compare process: every cycle once out of the initial reset
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx", tx, busy_m ? bits_m[t_m / CPB] : 1'b1);
      check("busy", busy, busy_m);
      check("frame_done", frame_done, busy_m && (t_m == TOTAL - 1));
      check("drop_cnt", drop_cnt, drop_m);
    end
  end

  // ---------------- line decoder / scoreboard ----------------
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         rx_act = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh;

  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin rx_act = 1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB + CPB/2 && ((rx_cnt - CPB/2) % CPB) == 0) begin
        k = (rx_cnt - CPB/2) / CPB;
        if (k <= 8) rx_sh[k-1] = tx;
        else begin
          check("stop_bit", tx, 1'b1);
          rx_q.push_back(rx_sh);
          rx_act = 0;
        end
      end
    end
  end

  task automatic push_frame(input logic [15:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] znc);
    logic [7:0] cs;
    exp_q.push_back(8'hA5);
    exp_q.push_back(op[15:8]); exp_q.push_back(op[7:0]);
    exp_q.push_back(a[15:8]);  exp_q.push_back(a[7:0]);
    exp_q.push_back(b[15:8]);  exp_q.push_back(b[7:0]);
    exp_q.push_back({5'b0, znc});
    cs = op[15:8] ^ op[7:0] ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ {5'b0, znc};
`ifdef TRACE_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic check_rx(input string name);
    check({name, "_nbytes"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      logic [7:0] e, r;
      e = exp_q.pop_front();
      r = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check({name, "_byte"}, r, e);
    end
    rx_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input logic [15:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [2:0] znc);
    op_in = op; a_in = a; b_in = b; znc_in = znc;
  endtask

  task automatic capture_pulse();
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
  endtask

  // Runs until busy drops; optionally injects refused captures and input noise.
  task automatic wait_idle(output int busy_cyc, output int fd_cyc, input int n_drops,
                           input bit drop_on_done, input bit scramble);
    int c;
    busy_cyc = 0; fd_cyc = 0; c = 0;
    while (busy === 1'b1 && c < 4000) begin
      busy_cyc++;
      if (frame_done === 1'b1) begin
        fd_cyc++;
        if (drop_on_done) capture = 1'b1;
      end
      if (n_drops > 0 && c >= 50 && (c % 37) == 0) begin
        capture = 1'b1; n_drops--;
      end
      if (scramble && c == 20)
        drive_inputs(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                     16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)));
      @(negedge clk);
      capture = 1'b0;
      c++;
    end
    check("frame_ends_in_time", c < 4000, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int bc, fc;
    rst_n = 1'b0; capture = 1'b0;
    drive_inputs(16'h0, 16'h0, 16'h0, 3'b0);
    repeat (4) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_drop_cnt", drop_cnt, 8'd0);
    cmp_en = 1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single frame, inputs scrambled mid-frame
    drive_inputs(16'h1234, 16'h00FF, 16'h8001, 3'b101);
    capture_pulse();
    check("start_bit_after_accept", tx, 1'b0);
    check("busy_after_accept", busy, 1'b1);
    wait_idle(bc, fc, 0, 0, 1);
    check("single_busy_cycles", bc, BUSY_LIT);
    check("single_frame_done_pulses", fc, 1);
    exp_q = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h05};
`ifdef TRACE_CHECKSUM_EN
    exp_q.push_back(8'h5D);
`endif
    check_rx("single");
    repeat (2) @(negedge clk);

    // refused captures: 3 mid-frame plus one during frame_done
    drive_inputs(16'hBEEF, 16'h0102, 16'hFEDC, 3'b010);
    capture_pulse();
    wait_idle(bc, fc, 3, 1, 0);
    check("drop_cnt_four", drop_cnt, 8'd4);
    check("drop_busy_cycles", bc, BUSY_LIT);
    push_frame(16'hBEEF, 16'h0102, 16'hFEDC, 3'b010);
    check_rx("drop");
    repeat (2) @(negedge clk);

    // saturation: 300 refused captures
    drive_inputs(16'h5A5A, 16'hC3C3, 16'h0F0F, 3'b111);
    capture_pulse();
    capture = 1'b1;
    repeat (300) @(negedge clk);
    capture = 1'b0;
    wait_idle(bc, fc, 0, 0, 0);
    check("drop_cnt_saturated", drop_cnt, 8'd255);
    push_frame(16'h5A5A, 16'hC3C3, 16'h0F0F, 3'b111);
    check_rx("saturate");
    repeat (2) @(negedge clk);

    // back-to-back: capture in the first cycle after busy falls
    drive_inputs(16'h0001, 16'h8000, 16'h7FFF, 3'b001);
    capture_pulse();
    wait_idle(bc, fc, 0, 0, 0);
    check("b2b_idle_cycle_busy", busy, 1'b0);
    drive_inputs(16'hFFFF, 16'h0000, 16'hA55A, 3'b100);
    capture_pulse();
    check("b2b_second_start_bit", tx, 1'b0);
    check("b2b_second_busy", busy, 1'b1);
    wait_idle(bc, fc, 0, 0, 0);
    check("b2b_second_busy_cycles", bc, BUSY_LIT);
    push_frame(16'h0001, 16'h8000, 16'h7FFF, 3'b001);
    push_frame(16'hFFFF, 16'h0000, 16'hA55A, 3'b100);
    check_rx("b2b");
    repeat (2) @(negedge clk);

    // reset during byte 3
    drive_inputs(16'h1111, 16'h2222, 16'h3333, 3'b011);
    capture_pulse();
    repeat (3 * 10 * CPB + 5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_drop_cnt", drop_cnt, 8'd0);
    rst_n = 1'b1;
    rx_q.delete();
    @(negedge clk);
    drive_inputs(16'h4321, 16'h00AA, 16'h5500, 3'b110);
    capture_pulse();
    wait_idle(bc, fc, 0, 0, 0);
    check("post_reset_busy_cycles", bc, BUSY_LIT);
    check("post_reset_frame_done_pulses", fc, 1);
    push_frame(16'h4321, 16'h00AA, 16'h5500, 3'b110);
    check_rx("post_reset");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
